// File: rtl/serial_7seg_receiver_pkg.sv
// Shared constants for the serial 7-segment receiver: segment patterns, frame byte layout, FSM encoding.
// Pure definitions; no latency or flow control of its own.
package serial_7seg_receiver_pkg;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   // Frame byte is {dp, g, f, e, d, c, b, a}
   localparam int DP_BIT = 7;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } rx_state_e;

endpackage

// File: rtl/serial_7seg_receiver_seg7_to_bcd.sv
// Combinational active-high 7-segment pattern to BCD decode; zero latency, no flow control.
// Unknown patterns (including blank) give BCD_INVALID with valid_o low.
module seg7_to_bcd
   import serial_7seg_receiver_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       valid_o
);

   always_comb begin
      bcd_o   = BCD_INVALID;
      valid_o = 1'b1;
      case (seg_i)
         SEG_0:   bcd_o = 4'd0;
         SEG_1:   bcd_o = 4'd1;
         SEG_2:   bcd_o = 4'd2;
         SEG_3:   bcd_o = 4'd3;
         SEG_4:   bcd_o = 4'd4;
         SEG_5:   bcd_o = 4'd5;
         SEG_6:   bcd_o = 4'd6;
         SEG_7:   bcd_o = 4'd7;
         SEG_8:   bcd_o = 4'd8;
         SEG_9:   bcd_o = 4'd9;
         default: valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_7seg_receiver.sv
// Oversampling 3-wire display receiver; outputs/strobes move SYNC_STAGES+2 cycles after raw latch rise.
// No backpressure (the sender free-runs); RX_TIMEOUT_EN adds a partial-frame inactivity timeout.
module serial_7seg_receiver
   import serial_7seg_receiver_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic       i_serial_clk,
   input  logic       i_serial_data,
   input  logic       i_serial_latch,
   output logic [3:0] o_hours_msb,
   output logic [3:0] o_hours_lsb,
   output logic [3:0] o_minutes_msb,
   output logic [3:0] o_minutes_lsb,
   output logic [3:0] o_seconds_msb,
   output logic [3:0] o_seconds_lsb,
   output logic [5:0] o_dp,
   output logic       o_frame_stb,
   output logic       o_frame_err,
   output logic       o_seg_err
);

   localparam int FRAME_BITS = 8 * NUM_DIGITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q, lat_sync_q;
   logic                   clk_prev_q, lat_prev_q;
   logic                   clk_rise, lat_rise, dat_bit;

   rx_state_e              state_q, state_d;
   logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   commit_ok, commit_bad;

   logic [3:0]             digit_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]  dp_q;
   logic                   stb_q, err_q, seg_err_q;

   logic [3:0]             dec_bcd [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]  dec_vld;

`ifdef RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Data is tapped at the same depth as the clock edge detector, so it is the bit present at the edge
   assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
   assign lat_rise = lat_sync_q[SYNC_STAGES-1] & ~lat_prev_q;
   assign dat_bit  = dat_sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         clk_sync_q <= '0;
         dat_sync_q <= '0;
         lat_sync_q <= '0;
         clk_prev_q <= 1'b0;
         lat_prev_q <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], i_serial_data};
         lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], i_serial_latch};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
         lat_prev_q <= lat_sync_q[SYNC_STAGES-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      commit_ok  = 1'b0;
      commit_bad = 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif
      if (i_en) begin
         case (state_q)
            ST_IDLE, ST_SHIFT: begin
               if (clk_rise) begin
                  shreg_d = {shreg_q[FRAME_BITS-2:0], dat_bit};
                  if (cnt_q != CNT_OVF) cnt_d = cnt_q + 1'b1;
                  state_d = ST_SHIFT;
               end
               // A latch in the same cycle as a clock rise commits the just-shifted bit too
               if (lat_rise) state_d = ST_COMMIT;
`ifdef RX_TIMEOUT_EN
               tmo_d = '0;
               if (state_q == ST_SHIFT && !clk_rise && !lat_rise) begin
                  if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end else begin
                     tmo_d = tmo_q + 1'b1;
                  end
               end
`endif
            end
            ST_COMMIT: begin
               if (cnt_q == CNT_FULL) commit_ok  = 1'b1;
               else                   commit_bad = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
`ifdef RX_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
            default: begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef RX_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) tmo_q <= '0;
      else            tmo_q <= tmo_d;
   end
`endif

   // Digit 0 (hours_msb) is the first byte shifted, so it sits at the top of the shift register
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      seg7_to_bcd u_dec (
         .seg_i   (shreg_q[8*(NUM_DIGITS-1-gi) +: 7]),
         .bcd_o   (dec_bcd[gi]),
         .valid_o (dec_vld[gi])
      );
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
         dp_q      <= '0;
         stb_q     <= 1'b0;
         err_q     <= 1'b0;
         seg_err_q <= 1'b0;
      end else begin
         stb_q <= commit_ok;
         err_q <= commit_bad;
         if (commit_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               digit_q[i] <= dec_bcd[i];
               dp_q[i]    <= shreg_q[8*i + DP_BIT];
            end
            seg_err_q <= ~&dec_vld;
         end
      end
   end

   assign o_hours_msb   = digit_q[0];
   assign o_hours_lsb   = digit_q[1];
   assign o_minutes_msb = digit_q[2];
   assign o_minutes_lsb = digit_q[3];
   assign o_seconds_msb = digit_q[4];
   assign o_seconds_lsb = digit_q[5];
   assign o_dp          = dp_q;
   assign o_frame_stb   = stb_q;
   assign o_frame_err   = err_q;
   assign o_seg_err     = seg_err_q;

endmodule

// File: tb/tb_serial_7seg_receiver.sv
// Bench for serial_7seg_receiver: table of frames plus hand sequences, checked through a pulse scoreboard.
module tb_serial_7seg_receiver;

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   logic i_en = 1'b0;
   logic sclk = 1'b0;
   logic sdat = 1'b0;
   logic slat = 1'b0;
   logic [3:0] h_msb, h_lsb, m_msb, m_lsb, s_msb, s_lsb;
   logic [5:0] dp;
   logic frame_stb, frame_err, seg_err;

   serial_7seg_receiver #(
      .NUM_DIGITS     (6),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_en           (i_en),
      .i_serial_clk   (sclk),
      .i_serial_data  (sdat),
      .i_serial_latch (slat),
      .o_hours_msb    (h_msb),
      .o_hours_lsb    (h_lsb),
      .o_minutes_msb  (m_msb),
      .o_minutes_lsb  (m_lsb),
      .o_seconds_msb  (s_msb),
      .o_seconds_lsb  (s_lsb),
      .o_dp           (dp),
      .o_frame_stb    (frame_stb),
      .o_frame_err    (frame_err),
      .o_seg_err      (seg_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        stb;
      logic [23:0] digits;
      logic [5:0]  dp;
      logic        seg_err;
   } exp_t;

   typedef struct {
      logic [23:0] digits;
      logic [5:0]  dp;
      int          nbits;
   } vec_t;

   exp_t sb_q[$];
   exp_t model = '0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [47:0] mk_frame(input logic [23:0] dg, input logic [5:0] dpv);
      logic [47:0] f;
      f = '0;
      for (int i = 0; i < 6; i++) f[47-8*i -: 8] = {dpv[5-i], seg_of(dg[23-4*i -: 4])};
      return f;
   endfunction

   function automatic logic has_bad(input logic [23:0] dg);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 6; i++) if (dg[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   function automatic logic [23:0] cur_digits();
      return {h_msb, h_lsb, m_msb, m_lsb, s_msb, s_lsb};
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic send_bit(input logic b);
      sdat = b;
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
   endtask

   // Bits past 48 are padding ones, used for the over-length case
   task automatic send_bits(input logic [47:0] f, input int n);
      for (int i = 0; i < n; i++) send_bit(i < 48 ? f[47-i] : 1'b1);
   endtask

   task automatic pulse_latch();
      wait_cyc(4);
      slat = 1'b1;
      lat_cyc = cyc;
      wait_cyc(4);
      slat = 1'b0;
   endtask

   task automatic expect_frame(input logic [23:0] dg, input logic [5:0] dpv, input logic valid);
      exp_t e;
      if (valid) begin
         e.stb     = 1'b1;
         e.digits  = dg;
         e.dp      = dpv;
         e.seg_err = has_bad(dg);
         model     = e;
      end else begin
         e     = model;
         e.stb = 1'b0;
      end
      sb_q.push_back(e);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 60) begin
         wait_cyc(1);
         t++;
      end
      wait_cyc(4);
      chk(name, 32'(sb_q.size()), 32'd0);
   endtask

   // Scoreboard: every strobe/error pulse must match the oldest pending expectation
   always @(negedge i_clk) begin
      exp_t e;
      if (i_reset_n && (frame_stb || frame_err)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse", 32'({frame_stb, frame_err}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("pulse_kind", 32'({frame_stb, frame_err}), e.stb ? 32'd2 : 32'd1);
            chk("digits", 32'(cur_digits()), 32'(e.digits));
            chk("dp", 32'(dp), 32'(e.dp));
            chk("seg_err", 32'(seg_err), 32'(e.seg_err));
            chk("latency", 32'(cyc - lat_cyc), 32'd4);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [7];
      logic [47:0] f;

      tbl[0] = '{24'h123456, 6'b001100, 48};
      tbl[1] = '{24'h123456, 6'b000000, 47};
      tbl[2] = '{24'h987654, 6'b000000, 50};
      tbl[3] = '{24'h123F56, 6'b000000, 48};
      tbl[4] = '{24'h235901, 6'b000001, 48};
      tbl[5] = '{24'h000000, 6'b000000, 0};
      tbl[6] = '{24'h000000, 6'b111111, 48};

      wait_cyc(5);
      chk("rst_digits", 32'(cur_digits()), 32'd0);
      chk("rst_dp", 32'(dp), 32'd0);
      chk("rst_pulses", 32'({frame_stb, frame_err}), 32'd0);
      chk("rst_seg_err", 32'(seg_err), 32'd0);
      i_reset_n = 1'b1;
      i_en = 1'b1;
      wait_cyc(3);

      for (int i = 0; i < 7; i++) begin
         f = mk_frame(tbl[i].digits, tbl[i].dp);
         expect_frame(tbl[i].digits, tbl[i].dp, tbl[i].nbits == 48);
         send_bits(f, tbl[i].nbits);
         pulse_latch();
         drain($sformatf("drain_vec%0d", i));
      end

      // Reset in the middle of a frame
      send_bits(mk_frame(24'h111111, 6'b0), 20);
      wait_cyc(2);
      i_reset_n = 1'b0;
      wait_cyc(3);
      chk("midrst_digits", 32'(cur_digits()), 32'd0);
      chk("midrst_dp", 32'(dp), 32'd0);
      chk("midrst_seg_err", 32'(seg_err), 32'd0);
      model = '0;
      i_reset_n = 1'b1;
      wait_cyc(3);
      expect_frame(24'h095959, 6'b0, 1'b1);
      send_bits(mk_frame(24'h095959, 6'b0), 48);
      pulse_latch();
      drain("drain_midrst");

      // Latch rise together with the 48th clock rise
      f = mk_frame(24'h214207, 6'b100000);
      expect_frame(24'h214207, 6'b100000, 1'b1);
      send_bits(f, 47);
      sdat = f[0];
      wait_cyc(4);
      sclk = 1'b1;
      slat = 1'b1;
      lat_cyc = cyc;
      wait_cyc(4);
      sclk = 1'b0;
      slat = 1'b0;
      drain("drain_simul");

      // Disabled receiver ignores a full frame and latch
      i_en = 1'b0;
      send_bits(mk_frame(24'h777777, 6'b0), 48);
      pulse_latch();
      wait_cyc(10);
      i_en = 1'b1;
      wait_cyc(3);
      chk("en_low_hold", 32'(cur_digits()), 32'(model.digits));
      expect_frame(24'h135790, 6'b010000, 1'b1);
      send_bits(mk_frame(24'h135790, 6'b010000), 48);
      pulse_latch();
      drain("drain_reenable");

`ifdef RX_TIMEOUT_EN
      send_bits(mk_frame(24'h555555, 6'b0), 10);
      wait_cyc(100);
      expect_frame(24'h102030, 6'b0, 1'b1);
      send_bits(mk_frame(24'h102030, 6'b0), 48);
      pulse_latch();
      drain("drain_timeout");
`endif

      wait_cyc(20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
